// File: rtl/ctrl_pipe_hazard.sv
// Stall/flush-aware control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use bubble insertion.
// One cycle per stage; stall_all freezes every stage, id_hold tells PC and IF/ID to hold.
module ctrl_pipe_hazard #(
  parameter int CTRL_W    = 8,
  parameter int MEMRD_BIT = 1,
  parameter int REGWR_BIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic [4:0]        rd_in,
  input  logic [4:0]        rn_in,
  input  logic [4:0]        rm_in,
  input  logic              use_rn,
  input  logic              use_rm,
  input  logic              stall_all,
  input  logic              flush,
  output logic              id_hold,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_rd,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [4:0]        mem_rd,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [4:0]        wb_rd,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  if (MEMRD_BIT >= CTRL_W || REGWR_BIT >= CTRL_W) begin : g_bad_bit_index
    $error("control bit index outside the control bundle");
  end

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic              vld;
  } stage_t;

  localparam stage_t BUBBLE = '{ctrl: '0, rd: 5'd31, vld: 1'b0};

  stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_match;
  logic             hazard;

  // XZR destination never creates a dependency, even for a load.
  always_comb begin
    src_match = (use_rn && (rn_in == ex_q.rd)) || (use_rm && (rm_in == ex_q.rd));
    hazard    = valid_in && ex_q.vld && ex_q.ctrl[MEMRD_BIT] &&
                (ex_q.rd != 5'd31) && src_match;
  end

  assign id_hold = (hazard | stall_all) & ~reset;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!stall_all) begin
      wb_d = mem_q;
      if (flush) begin
        ex_d  = BUBBLE;
        mem_d = BUBBLE;
      end else if (hazard) begin
        ex_d  = BUBBLE;
        mem_d = ex_q;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        mem_d = ex_q;
        ex_d  = valid_in ? '{ctrl: ctrl_in, rd: rd_in, vld: 1'b1} : BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_ctrl   = ex_q.ctrl;
  assign ex_rd     = ex_q.rd;
  assign ex_valid  = ex_q.vld;
  assign mem_ctrl  = mem_q.ctrl;
  assign mem_rd    = mem_q.rd;
  assign mem_valid = mem_q.vld;
  assign wb_ctrl   = wb_q.ctrl;
  assign wb_rd     = wb_q.rd;
  assign wb_valid  = wb_q.vld;
  assign stall_cnt = cnt_q;

endmodule
